// File: rtl/pipeline_controller_pkg.sv
// Shared encodings and scoreboard slot layout for the pipeline hazard controller.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    CTL_RUN      = 2'd0,
    CTL_MEM_WAIT = 2'd1,
    CTL_FLUSH    = 2'd2
  } ctl_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
  } slot_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// ID/EX status in, stall/flush/forward controls out, between datapath and controller.
interface pipeline_controller_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_wr;
  logic       id_load;
  logic       ex_redirect;
  logic       mem_wait;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       bubble_ex;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr, id_load,
           ex_redirect, mem_wait,
    input  stall_if, stall_id, stall_ex, bubble_ex, flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr, id_load,
           ex_redirect, mem_wait,
    output stall_if, stall_id, stall_ex, bubble_ex, flush, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipeline_controller_fwd_select.sv
// Operand bypass select for one EX source register; MEM result wins over WB.
module fwd_select
  import pipeline_controller_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic       mem_valid,
  input  logic       mem_wr,
  input  logic [4:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_wr,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  logic live;
  assign live = use_rs && (rs != 5'd0);

  always_comb begin
    sel = FWD_RF;
    if (live && mem_valid && mem_wr && (mem_rd == rs))
      sel = FWD_MEM;
    else if (live && wb_valid && wb_wr && (wb_rd == rs))
      sel = FWD_WB;
  end
endmodule

// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: EX/MEM/WB scoreboard,
// load-use interlock, memory-wait freeze, redirect flush and EX forwarding.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_controller_if.slave ctl
);
  ctl_state_e state, nstate;
  logic [2:0] cnt, ncnt;
  slot_t      slot_ex, slot_mem, slot_wb, id_slot;
  logic       stall_if, stall_id, stall_ex, bubble_ex, flush, advance, load_use;
  logic [1:0] fwd_a, fwd_b;

  assign id_slot = '{valid: ctl.id_valid, rd: ctl.id_rd, wr: ctl.id_wr, load: ctl.id_load,
                     rs1: ctl.id_rs1, rs2: ctl.id_rs2,
                     use1: ctl.id_use_rs1, use2: ctl.id_use_rs2};

  // rd != 0 already implies the matching ID source is not x0
  assign load_use = slot_ex.valid && slot_ex.load && slot_ex.wr && (slot_ex.rd != 5'd0) &&
                    ctl.id_valid &&
                    ((ctl.id_use_rs1 && (ctl.id_rs1 == slot_ex.rd)) ||
                     (ctl.id_use_rs2 && (ctl.id_rs2 == slot_ex.rd)));

  always_comb begin
    nstate    = state;
    ncnt      = cnt;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush     = 1'b0;
    advance   = 1'b1;
    case (state)
      CTL_FLUSH: begin
        flush = 1'b1;
        if (ctl.mem_wait) begin
          // freeze counter and slots; flush stays up, no bubble while ID/EX is held
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          advance  = 1'b0;
        end else begin
          bubble_ex = 1'b1;
          ncnt      = cnt - 3'd1;
          if (cnt <= 3'd1) nstate = CTL_RUN;
        end
      end
      default: begin
        // RUN, and MEM_WAIT once memory is ready (RUN rules apply that same cycle)
        nstate = CTL_RUN;
        if (ctl.mem_wait) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          advance  = 1'b0;
          nstate   = CTL_MEM_WAIT;
        end else if (ctl.ex_redirect) begin
          flush     = 1'b1;
          bubble_ex = 1'b1;
          ncnt      = 3'(FLUSH_CYCLES - 1);
          nstate    = (FLUSH_CYCLES > 1) ? CTL_FLUSH : CTL_RUN;
        end else if (load_use) begin
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CTL_RUN;
      cnt      <= '0;
      slot_ex  <= '0;
      slot_mem <= '0;
      slot_wb  <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (advance) begin
        slot_wb  <= slot_mem;
        slot_mem <= slot_ex;
        slot_ex  <= (bubble_ex || flush) ? '0 : id_slot;
      end
    end
  end

  fwd_select u_fwd_a (
    .rs(slot_ex.rs1), .use_rs(slot_ex.use1),
    .mem_valid(slot_mem.valid), .mem_wr(slot_mem.wr), .mem_rd(slot_mem.rd),
    .wb_valid(slot_wb.valid), .wb_wr(slot_wb.wr), .wb_rd(slot_wb.rd),
    .sel(fwd_a)
  );

  fwd_select u_fwd_b (
    .rs(slot_ex.rs2), .use_rs(slot_ex.use2),
    .mem_valid(slot_mem.valid), .mem_wr(slot_mem.wr), .mem_rd(slot_mem.rd),
    .wb_valid(slot_wb.valid), .wb_wr(slot_wb.wr), .wb_rd(slot_wb.rd),
    .sel(fwd_b)
  );

  // source fields of MEM/WB are carried for uniform slot shifting only
  logic unused_slot_bits;
  assign unused_slot_bits = ^{slot_mem.load, slot_mem.rs1, slot_mem.rs2, slot_mem.use1,
                              slot_mem.use2, slot_wb.load, slot_wb.rs1, slot_wb.rs2,
                              slot_wb.use1, slot_wb.use2};

  assign ctl.stall_if  = rst_n && stall_if;
  assign ctl.stall_id  = rst_n && stall_id;
  assign ctl.stall_ex  = rst_n && stall_ex;
  assign ctl.bubble_ex = rst_n && bubble_ex;
  assign ctl.flush     = !rst_n || flush;
  assign ctl.fwd_a     = rst_n ? fwd_a : FWD_RF;
  assign ctl.fwd_b     = rst_n ? fwd_b : FWD_RF;
endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Hazard and sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Keeps a registered scoreboard of the instructions in EX, MEM and WB.
- From that scoreboard and the stage-status inputs it issues stall, bubble and flush controls and the EX operand forwarding selects.
- Sits beside the decoder: it receives the ID-stage register usage and the EX-stage redirect and memory-wait status.

Parameters:
- FLUSH_CYCLES, 2: cycles flush stays asserted after a redirect, covering fetch latency; legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  source register 1 of the ID instruction.
- id_rs2  in  5  source register 2 of the ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  5  destination register of the ID instruction.
- id_wr  in  1  ID instruction writes rd.
- id_load  in  1  ID instruction is a load (info_load != NOTLOAD).
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX.
- mem_wait  in  1  data memory not ready for the MEM-stage access.
- stall_if  out  1  hold PC and the IF/ID register.
- stall_id  out  1  hold the ID/EX register.
- stall_ex  out  1  hold the EX/MEM and MEM/WB registers.
- bubble_ex  out  1  load NOP (write_reg=0, NOTLOAD/NOTSTORE/NOTBRANCH) into ID/EX.
- flush  out  1  kill the IF and ID contents.
- fwd_a  out  2  EX rs1 source: 0 register file, 1 MEM result, 2 WB result.
- fwd_b  out  2  EX rs2 source, same encoding as fwd_a.

Behaviour:
- Reset:
  - Sampled rst_n=0 clears all slots (valid=0), sets state to RUN and the counter to 0.
  - While rst_n=0, outputs are forced to stall_*=0, bubble_ex=0, flush=1, fwd_*=0.
- Scoreboard:
  - Three slots (EX, MEM, WB), each holding {valid, rd, wr, load, rs1, rs2, use1, use2}.
  - On an advancing cycle: WB <= MEM, MEM <= EX, and EX <= ID fields (valid = id_valid), or invalid when bubble_ex=1 or flush=1.
- Outputs are combinational from state, slots and current inputs, taking effect in the same cycle.
- Forwarding, per EX operand:
  - sel=1 if MEM.valid & MEM.wr & MEM.rd == EX.rs & rs != 0 & EX.use.
  - Otherwise sel=2 under the same test against WB.
  - Otherwise sel=0. MEM has priority over WB.
  - A MEM slot holding a load never forwards as sel=1; the load-use stall guarantees this case never arises.
- Load-use hazard:
  - Condition: EX.valid & EX.load & EX.wr & EX.rd != 0, and EX.rd matches id_rs1 (with use1) or id_rs2 (with use2), and id_valid.
  - Response: stall_if=1, stall_id=0, bubble_ex=1 for exactly one cycle.
- FSM states: RUN, MEM_WAIT, FLUSH.
  - RUN, mem_wait=1: stall_if=stall_id=stall_ex=1, no slot movement, go to MEM_WAIT.
    - mem_wait overrides redirect and load-use in the same cycle.
  - RUN, ex_redirect=1: flush=1, bubble_ex=1, slots advance, counter <= FLUSH_CYCLES-1.
    - Go to FLUSH if FLUSH_CYCLES>1, otherwise stay in RUN.
  - RUN, otherwise: apply the load-use rule.
  - MEM_WAIT: all stalls held while mem_wait=1, no slot movement.
    - When mem_wait=0: return to RUN and evaluate RUN rules that same cycle.
    - A redirect held in frozen EX is acted on then.
  - FLUSH: flush=1, bubble_ex=1, slots advance, counter decrements; go to RUN when counter reaches 1.
    - mem_wait=1 in FLUSH: freeze slots and counter, keep flush=1, return to FLUSH afterward (no MEM_WAIT detour).
    - ex_redirect=1 in FLUSH is ignored; EX only holds bubbles.
- Register x0 never causes stalls or forwarding.
- bubble_ex and stall_id are never asserted together.

Decomposition:
- Shared package / define file holds:
  - State encodings CTL_RUN, CTL_MEM_WAIT, CTL_FLUSH.
  - Forward selects FWD_RF=0, FWD_MEM=1, FWD_WB=2.
  - The slot field layout.
- One sub-module, fwd_select:
  - Combinational; takes an operand's rs and use, plus the MEM and WB slot fields; returns the 2-bit select.
  - Instantiated twice (fwd_a, fwd_b).

Test Plan:
- Back-to-back ALU dependence: slot EX writes x5; next ID reads x5 in rs1 -> one cycle later fwd_a=1, no stall; following cycle an instruction reading x5 gets fwd_a=2.
- Load-use: EX=load x7, id_rs2=x7 with use2=1 -> stall_if=1, bubble_ex=1 for exactly 1 cycle, then fwd_b=2 on the dependent instruction in EX.
- x0: EX=load x0, ID reads x0 -> no stall; fwd_a=fwd_b=0.
- Redirect with FLUSH_CYCLES=2 -> flush=1 for exactly 2 cycles, both EX slots invalid; state returns to RUN.
- mem_wait held 3 cycles while ex_redirect=1 -> stalls for 3 cycles, no flush; on the 4th cycle flush=1 and stalls drop.
- Reset in FLUSH mid-count with a dependent load in EX -> after reset: no stall, flush=0 once rst_n=1, slots invalid, fwd_*=0.
